// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - enable-gated register pipeline with valid/ready handshake and bubble collapsing
// Optional stall counter output enabled by defining DFF_PIPE_STATS_EN.
module dff_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             d,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             q,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef DFF_PIPE_STATS_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int OW = $clog2(DEPTH + 1);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("dff_pipe: DEPTH must be at least 1");
    end
  endgenerate

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_v;
  logic [OW-1:0]    r_occ;

  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_load;
  logic [DEPTH-1:0] w_v_nxt;
  logic [WIDTH-1:0] w_src [DEPTH];
  logic             w_in_xfer;
  logic [OW-1:0]    w_occ_nxt;

  // A stage advances when some later stage is empty, or the whole tail is full and drains.
  always_comb begin
    logic w_tail_full;
    w_tail_full = 1'b1;
    w_adv       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_adv[i]    = en & r_v[i] & (~w_tail_full | out_ready);
      w_tail_full = w_tail_full & r_v[i];
    end
  end

  assign in_ready  = en & ~clr & rst & (~r_v[0] | w_adv[0]);
  assign w_in_xfer = in_valid & in_ready;

  always_comb begin
    w_load[0] = w_in_xfer;
    w_src[0]  = d;
    for (int i = 1; i < DEPTH; i++) begin
      w_load[i] = w_adv[i-1];
      w_src[i]  = r_data[i-1];
    end
    w_v_nxt   = w_load | (r_v & ~w_adv);
    w_occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ_nxt = w_occ_nxt + OW'(w_v_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= RST_VAL;
      end
      r_v   <= '0;
      r_occ <= '0;
    end else if (clr) begin
      r_v   <= '0;
      r_occ <= '0;
    end else if (en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_load[i]) begin
          r_data[i] <= w_src[i];
        end
      end
      r_v   <= w_v_nxt;
      r_occ <= w_occ_nxt;
    end
  end

  assign q         = r_data[DEPTH-1];
  assign out_valid = r_v[DEPTH-1] & en;
  assign occupancy = r_occ;

`ifdef DFF_PIPE_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (clr) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// tb/tb_dff_pipe.sv - directed vector bench for dff_pipe (WIDTH=8, DEPTH=4)
// Stall counter checks are compiled in when DFF_PIPE_STATS_EN is defined.
module tb_dff_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic [OW-1:0]    occupancy;
`ifdef DFF_PIPE_STATS_EN
  logic [15:0]      stall_cnt;
`endif

  bit clk_run = 1'b1;
  int total = 0;
  int bad   = 0;

  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(8'h00)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .occupancy (occupancy)
`ifdef DFF_PIPE_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    logic       en;
    logic       clr;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [7:0] q;
    logic [2:0] occ;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic iv, input logic [7:0] dd, input logic o);
    en = e; clr = c; in_valid = iv; d = dd; out_ready = o;
  endtask

  task automatic add(input logic iv, input logic [7:0] dd, input logic o,
                     input logic ir, input logic ov, input logic [7:0] qq, input logic [2:0] oc);
    vec_t v;
    v.en = 1'b1; v.clr = 1'b0; v.iv = iv; v.d = dd; v.ordy = o;
    v.ir = ir; v.ov = ov; v.q = qq; v.occ = oc;
    tbl.push_back(v);
  endtask

  logic [7:0] fz_q   [5];
  logic       fz_ov  [5];
  logic [2:0] fz_occ [5];

  initial begin
    // latency: single item through an empty pipe
    add(1, 8'hAA, 1, 1, 0, 8'h00, 0);
    add(0, 8'h00, 1, 1, 0, 8'h00, 1);
    add(0, 8'h00, 1, 1, 0, 8'h00, 1);
    add(0, 8'h00, 1, 1, 0, 8'h00, 1);
    add(0, 8'h00, 1, 1, 1, 8'hAA, 1);
    add(0, 8'h00, 1, 1, 0, 8'hAA, 0);
    // backpressure then full-rate drain
    add(1, 8'hAA, 0, 1, 0, 8'hAA, 0);
    add(1, 8'hFF, 0, 1, 0, 8'hAA, 1);
    add(1, 8'hA0, 0, 1, 0, 8'hAA, 2);
    add(1, 8'h55, 0, 1, 0, 8'hAA, 3);
    add(1, 8'h11, 0, 0, 1, 8'hAA, 4);
    add(1, 8'h11, 1, 1, 1, 8'hAA, 4);
    add(0, 8'h00, 1, 1, 1, 8'hFF, 4);
    add(0, 8'h00, 1, 1, 1, 8'hA0, 3);
    add(0, 8'h00, 1, 1, 1, 8'h55, 2);
    add(0, 8'h00, 1, 1, 1, 8'h11, 1);
    add(0, 8'h00, 1, 1, 0, 8'h11, 0);
    // bubble collapse under stall, then ordered drain
    add(1, 8'hAA, 0, 1, 0, 8'h11, 0);
    add(0, 8'h00, 0, 1, 0, 8'h11, 1);
    add(0, 8'h00, 0, 1, 0, 8'h11, 1);
    add(1, 8'hFF, 0, 1, 0, 8'h11, 1);
    add(0, 8'h00, 0, 1, 1, 8'hAA, 2);
    add(0, 8'h00, 0, 1, 1, 8'hAA, 2);
    add(0, 8'h00, 0, 1, 1, 8'hAA, 2);
    add(0, 8'h00, 0, 1, 1, 8'hAA, 2);
    add(0, 8'h00, 1, 1, 1, 8'hAA, 2);
    add(0, 8'h00, 1, 1, 1, 8'hFF, 1);
    add(0, 8'h00, 1, 1, 0, 8'hFF, 0);

    fz_ov  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    fz_q   = '{8'hFF, 8'h01, 8'h02, 8'h03, 8'h03};
    fz_occ = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};

    // reset with clock running
    rst = 1'b0;
    drive(1, 0, 0, 8'h00, 0);
    #2;
    chk("rst.q", q, 8'h00);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.occupancy", occupancy, 0);
    chk("rst.in_ready", in_ready, 0);
    #10;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_release.in_ready", in_ready, 1);

    // fill, then asynchronous reset with the clock stopped
    tick();
    drive(1, 0, 1, 8'h5A, 0);
    repeat (4) tick();
    drive(1, 0, 0, 8'h00, 0);
    #1;
    chk("prefill.occupancy", occupancy, 4);
    chk("prefill.q", q, 8'h5A);
    @(negedge clk);
    clk_run = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst.q", q, 8'h00);
    chk("async_rst.out_valid", out_valid, 0);
    chk("async_rst.occupancy", occupancy, 0);
    chk("async_rst.in_ready", in_ready, 0);
    #5;
    rst = 1'b1;
    clk_run = 1'b1;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      #1;
      chk($sformatf("vec%0d.in_ready", i), in_ready, tbl[i].ir);
      chk($sformatf("vec%0d.out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("vec%0d.q", i), q, tbl[i].q);
      chk($sformatf("vec%0d.occupancy", i), occupancy, tbl[i].occ);
      tick();
    end

    // freeze with three items in flight
    drive(1, 0, 1, 8'h01, 0); tick();
    drive(1, 0, 1, 8'h02, 0); tick();
    drive(1, 0, 1, 8'h03, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 8'h99, 1);
      #1;
      chk($sformatf("freeze%0d.out_valid", i), out_valid, 0);
      chk($sformatf("freeze%0d.in_ready", i), in_ready, 0);
      chk($sformatf("freeze%0d.occupancy", i), occupancy, 3);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 8'h00, 1);
      #1;
      chk($sformatf("thaw%0d.out_valid", i), out_valid, fz_ov[i]);
      chk($sformatf("thaw%0d.q", i), q, fz_q[i]);
      chk($sformatf("thaw%0d.occupancy", i), occupancy, fz_occ[i]);
      tick();
    end

    // flush with a competing input
    drive(1, 0, 1, 8'h21, 0); tick();
    drive(1, 0, 1, 8'h22, 0); tick();
    drive(1, 0, 1, 8'h23, 0); tick();
    drive(1, 0, 0, 8'h00, 0); tick();
    #1;
    chk("preflush.occupancy", occupancy, 3);
    chk("preflush.q", q, 8'h21);
    drive(1, 1, 1, 8'h77, 0);
    #1;
    chk("flush.in_ready", in_ready, 0);
    tick();
    drive(1, 0, 0, 8'h00, 1);
    #1;
    chk("postflush.occupancy", occupancy, 0);
    chk("postflush.out_valid", out_valid, 0);
    chk("postflush.q", q, 8'h21);
`ifdef DFF_PIPE_STATS_EN
    chk("postflush.stall_cnt", stall_cnt, 0);
`endif
    repeat (4) tick();
    chk("no77.out_valid", out_valid, 0);
    chk("no77.occupancy", occupancy, 0);

    // one item stalled at the output for five edges
    drive(1, 0, 1, 8'h5C, 0); tick();
    drive(1, 0, 0, 8'h00, 0);
    repeat (3) tick();
    chk("stall.out_valid", out_valid, 1);
    chk("stall.q", q, 8'h5C);
    repeat (5) tick();
    chk("stall_hold.q", q, 8'h5C);
    chk("stall_hold.occupancy", occupancy, 1);
`ifdef DFF_PIPE_STATS_EN
    chk("stall_cnt", stall_cnt, 5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
Parametrised, enable-gated register pipeline. It generalises the single enabled WIDTH-bit register into DEPTH stages, with per-stage valid bits, a valid/ready handshake on both ends, and bubble collapsing. It sits between producer and consumer blocks that need fixed-minimum latency, retiming and backpressure. It also supports a global clock-enable freeze and a synchronous flush.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 4, number of register stages (>=1; DEPTH=0 is an elaboration error)
RST_VAL, 0, reset value loaded into every stage data register

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets)
en  input  1  global enable; 0 freezes all pipeline state
clr  input  1  synchronous flush; discards all stored items
in_valid  input  1  producer has data on d
in_ready  output  1  pipeline can accept d this cycle
d  input  WIDTH  input data
out_valid  output  1  q holds a valid item
out_ready  input  1  consumer accepts q this cycle
q  output  WIDTH  output data (last stage data register)
occupancy  output  clog2(DEPTH+1)  number of valid stages, registered

Behaviour:
- Reset (rst=0, asynchronous, no clock needed): all stage data = RST_VAL; all valid bits = 0; q = RST_VAL; occupancy = 0; out_valid = 0. in_ready = 0 while rst=0.
- Stage i (0..DEPTH-1) holds data_i and v_i. Stage DEPTH-1 drives q, and out_valid = v[DEPTH-1] & en.
- Advance rule for the last stage: adv[DEPTH-1] = v[DEPTH-1] & out_ready & en.
- Advance rule for stage i<DEPTH-1: adv[i] = v[i] & en & (~v[i+1] | adv[i+1]). This ripple is combinational; bubbles collapse.
- in_ready = en & ~clr & rst & (~v[0] | adv[0]). Input transfer = in_valid & in_ready.
- On a clock edge with en=1, clr=0:
  - stage i+1 loads data_i when adv[i] is 1;
  - stage 0 loads d on an input transfer;
  - a stage's valid bit clears when it advances and nothing is loaded into it.
  - Data registers load only on load events; otherwise they hold, so q holds its last value after draining.
- Latency: an item accepted at edge E on an empty, unstalled pipe is on q with out_valid=1 after edge E+DEPTH-1. Throughput is 1 item/cycle, including when full with out_ready=1: accept and drain occur in the same cycle.
- Ordering is strict FIFO. No item is ever duplicated or dropped except by clr or reset.
- en=0: no register changes, in_ready=0, out_valid=0. Occupancy is constant.
- clr=1 at an edge takes priority over en and over all transfers. All v cleared, occupancy=0, data registers unchanged. The in_ready=0 term in the clr cycle means no input is accepted.
- occupancy is updated at each edge to popcount(v) after the update.
- DEPTH=1: behaves as a single enabled register with handshake. in_ready = en & (~v0 | out_ready).

Optional Feature:
Macro DFF_PIPE_STATS_EN.
- Defined:
  - Adds output stall_cnt [15:0], reset to 0 asynchronously and cleared by clr.
  - stall_cnt increments at each edge where out_valid=1 and out_ready=0, saturating at 16'hFFFF.
  - en=0 cycles are not counted, because out_valid=0 when en=0.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset (WIDTH=8, DEPTH=4): hold rst=0 for 10 ns with en=1 and clk running, assert rst=0 again mid-stream with clk stopped → q=0x00, out_valid=0, occupancy=0 immediately; in_ready=1 on the first cycle after rst=1.
2. Latency: empty pipe, out_ready=1, push 0xAA at edge E → out_valid=1 with q=0xAA after edge E+3, for exactly one cycle; occupancy sequence 1,1,1,1,0.
3. Backpressure: out_ready=0, push 0xAA, 0xFF, 0xA0, 0x55 on consecutive cycles → occupancy=4, in_ready=0, 5th item 0x11 held. Then set out_ready=1 → q = 0xAA, 0xFF, 0xA0, 0x55, 0x11 on consecutive cycles; in_ready=1 in the first drain cycle.
4. Bubble collapse: push 0xAA, gap of 2 cycles, push 0xFF with out_ready=0 → after both settle, occupancy=2, v[3]=v[2]=1.
5. Freeze: 3 items in flight, en=0 for 5 cycles → out_valid=0, in_ready=0, occupancy=3 constant. On en=1 the items emerge in order with none lost.
6. Flush: 3 items stored plus clr=1 with in_valid=1 and d=0x77 → next cycle occupancy=0, out_valid=0, q unchanged, 0x77 not accepted. With DFF_PIPE_STATS_EN, stall_cnt=0 after clr, and it reaches 5 after 5 cycles of out_valid=1, out_ready=0.
